// File: rtl/div_issue_ctrl.sv
// Execute-stage controller for the multi-cycle divider: accepts DIV/DIVU
// requests, issues a one-cycle op pulse, commits the result to HI/LO,
// and handles MTHI/MTLO, flush cancellation and a timeout watchdog.
module div_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 40,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic        req_signed,
    input  logic [31:0] req_dividend,
    input  logic [31:0] req_divisor,
    output logic        req_ready,
    input  logic        flush,
    output logic        busy,
    input  logic        mthi_valid,
    input  logic        mtlo_valid,
    input  logic [31:0] mt_wdata,
    output logic [1:0]  div_op,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [63:0] div_result,
    input  logic        div_done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               div_signed_q;
    logic               cancel_q;
    logic [CNT_W-1:0]   wd_q;

    logic accept;
    logic wd_hit;
    logic wait_exit;
    logic capture;

    // req_ready is produced by the output process; accept only in IDLE.
    assign accept    = req_valid & req_ready;
    // Watchdog fires at the end of the TIMEOUT_CYCLES-th WAIT cycle without done.
    assign wd_hit    = (state_q == S_WAIT) & ~div_done &
                       ((wd_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));
    assign wait_exit = (state_q == S_WAIT) & (div_done | wd_hit);
    assign capture   = (state_q == S_WAIT) & div_done & ~cancel_q;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state is always written with non-blocking assignments
        // so every flop samples the pre-edge values regardless of block order.
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: the divider is never re-issued while it is counting,
    // so a flushed divide still drains through WAIT until done.
    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (div_done || wd_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: handshake, stall and the single-cycle op pulse.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b0;
        div_op    = 2'b00;
        case (state_q)
            S_IDLE: begin
                // flush suppresses acceptance, so it wins over a same-cycle request.
                req_ready = div_done & ~flush;
                busy      = req_valid & div_done & ~flush;
            end
            S_ISSUE: begin
                busy   = ~cancel_q;
                div_op = div_signed_q ? 2'b10 : 2'b01;
            end
            S_WAIT:  busy = ~cancel_q;
            default: ;
        endcase
    end

    // Operand and sign latch on acceptance; these drive the divider directly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_dividend <= '0;
            div_divisor  <= '0;
            div_signed_q <= 1'b0;
        end else if (accept) begin
            div_dividend <= req_dividend;
            div_divisor  <= req_divisor;
            div_signed_q <= req_signed;
        end
    end

    // Cancel flag: set by a flush while a divide is in flight, cleared when WAIT exits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                            cancel_q <= 1'b0;
        else if (wait_exit)                     cancel_q <= 1'b0;
        else if (flush && state_q != S_IDLE)    cancel_q <= 1'b1;
    end

    // Watchdog counter: cleared in ISSUE, counts WAIT cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                   wd_q <= '0;
        else if (state_q == S_ISSUE)   wd_q <= '0;
        else if (state_q == S_WAIT)    wd_q <= wd_q + CNT_W'(1);
    end

    // Sticky timeout error, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     err_timeout <= 1'b0;
        else if (wd_hit) err_timeout <= 1'b1;
    end

    // HI/LO: a committed divide result takes priority over MTHI/MTLO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (capture) begin
            hi <= div_result[63:32];
            lo <= div_result[31:0];
        end else begin
            if (mthi_valid) hi <= mt_wdata;
            if (mtlo_valid) lo <= mt_wdata;
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: a behavioural divider with fixed
// latency, and a transaction-level timeline model of the controller.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_signed = 1'b0;
    logic [31:0] req_dividend = '0;
    logic [31:0] req_divisor = '0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        busy;
    logic        mthi_valid = 1'b0;
    logic        mtlo_valid = 1'b0;
    logic [31:0] mt_wdata = '0;
    logic [1:0]  div_op;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [63:0] div_result;
    logic        div_done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err_timeout;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic        exp_err = 1'b0;

    // Divider environment model: done drops the cycle after the op pulse,
    // stays low 34 cycles, result valid when done rises again.
    logic        hang_mode = 1'b0;
    logic        stuck = 1'b0;
    int          dcnt = 0;
    logic [63:0] dres = '0;

    div_issue_ctrl dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_signed(req_signed),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .req_ready(req_ready), .flush(flush), .busy(busy),
        .mthi_valid(mthi_valid), .mtlo_valid(mtlo_valid), .mt_wdata(mt_wdata),
        .div_op(div_op), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_result(div_result), .div_done(div_done),
        .hi(hi), .lo(lo), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always @(posedge clk) begin
        if (div_op != 2'b00) begin
            dres  <= ref_div(div_op == 2'b10, div_dividend, div_divisor);
            dcnt  <= 34;
            stuck <= hang_mode;
        end else begin
            if (dcnt != 0) dcnt <= dcnt - 1;
            if (!hang_mode) stuck <= 1'b0;
        end
    end
    assign div_done   = (dcnt == 0) && !stuck;
    assign div_result = dres;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_arch(input string tag);
        check({tag, ".hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, ".lo"}, {32'd0, lo}, {32'd0, exp_lo});
        check({tag, ".err"}, {63'd0, err_timeout}, {63'd0, exp_err});
    endtask

    task automatic clear_inputs();
        req_valid  = 1'b0;
        flush      = 1'b0;
        mthi_valid = 1'b0;
        mtlo_valid = 1'b0;
    endtask

    // One idle cycle with optional MT write (sel: 0 hi, 1 lo, 2 both, -1 none).
    task automatic idle_cycle(input logic chk_ready, input int mt_sel, input logic [31:0] val);
        @(posedge clk); #1;
        clear_inputs();
        mthi_valid = (mt_sel == 0) || (mt_sel == 2);
        mtlo_valid = (mt_sel == 1) || (mt_sel == 2);
        mt_wdata   = val;
        @(negedge clk);
        check_arch("idle");
        check("idle.busy", {63'd0, busy}, 64'd0);
        check("idle.op", {62'd0, div_op}, 64'd0);
        if (chk_ready) check("idle.ready", {63'd0, req_ready}, 64'd1);
        if (mthi_valid) exp_hi = val;
        if (mtlo_valid) exp_lo = val;
    endtask

    // One divide transaction; cycle 0 is the accept cycle. The cycle after the
    // last one (37) is the next transaction's cycle 0 or an idle cycle.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input int mt_at, input int mt_sel,
                          input logic [31:0] mt_val, input int reset_at);
        logic [63:0] res;
        logic        exp_busy;
        res = ref_div(sgn, a, b);
        for (int c = 0; c <= 36; c++) begin
            @(posedge clk); #1;
            req_valid    = (c == 0);
            req_signed   = sgn;
            req_dividend = a;
            req_divisor  = b;
            flush        = (c == flush_at);
            mthi_valid   = (c == mt_at) && (mt_sel != 1);
            mtlo_valid   = (c == mt_at) && (mt_sel != 0);
            mt_wdata     = mt_val;
            if (c == reset_at) begin
                clear_inputs();
                #1 resetn = 1'b0;
                #1;
                exp_hi  = '0;
                exp_lo  = '0;
                exp_err = 1'b0;
                check_arch("rst_async");
                check("rst_async.busy", {63'd0, busy}, 64'd0);
                check("rst_async.op", {62'd0, div_op}, 64'd0);
                @(negedge clk);
                @(negedge clk);
                resetn = 1'b1;
                return;
            end
            @(negedge clk);
            if (c == 0) check("ready_accept", {63'd0, req_ready}, 64'd1);
            else        check("ready_low", {63'd0, req_ready}, 64'd0);
            exp_busy = !(flush_at >= 0 && c > flush_at);
            check("busy", {63'd0, busy}, {63'd0, exp_busy});
            check("op", {62'd0, div_op}, (c == 1) ? (sgn ? 64'd2 : 64'd1) : 64'd0);
            if (c == 1) begin
                check("opnd_a", {32'd0, div_dividend}, {32'd0, a});
                check("opnd_b", {32'd0, div_divisor}, {32'd0, b});
            end
            check_arch("div");
            if (mthi_valid) exp_hi = mt_val;
            if (mtlo_valid) exp_lo = mt_val;
            if (c == 36 && flush_at < 0) begin
                exp_hi = res[63:32];
                exp_lo = res[31:0];
            end
        end
    endtask

    // Divider never finishes: the watchdog must abort after 40 WAIT cycles.
    task automatic do_timeout(input logic [31:0] a, input logic [31:0] b);
        hang_mode = 1'b1;
        for (int c = 0; c <= 42; c++) begin
            @(posedge clk); #1;
            clear_inputs();
            req_valid    = (c == 0);
            req_signed   = 1'b0;
            req_dividend = a;
            req_divisor  = b;
            @(negedge clk);
            if (c == 0) check("to.ready", {63'd0, req_ready}, 64'd1);
            check("to.busy", {63'd0, busy}, (c <= 41) ? 64'd1 : 64'd0);
            check("to.op", {62'd0, div_op}, (c == 1) ? 64'd1 : 64'd0);
            check("to.err", {63'd0, err_timeout}, (c <= 41) ? 64'd0 : 64'd1);
            check("to.hi", {32'd0, hi}, {32'd0, exp_hi});
            check("to.lo", {32'd0, lo}, {32'd0, exp_lo});
        end
        exp_err   = 1'b1;
        hang_mode = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          fa;
        int          ma;

        // Reset state.
        #12;
        check_arch("reset");
        check("reset.busy", {63'd0, busy}, 64'd0);
        check("reset.op", {62'd0, div_op}, 64'd0);
        check("reset.opa", {32'd0, div_dividend}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        idle_cycle(1'b1, -1, '0);

        // Directed divides.
        do_div(1'b0, 32'd100, 32'd7, -1, -1, 0, '0, -1);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1, 0, '0, -1);
        idle_cycle(1'b1, -1, '0);
        check("div_signed_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        check("div_signed_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        do_div(1'b0, 32'd9, 32'd3, 10, -1, 0, '0, -1);
        do_div(1'b1, 32'd50, 32'd5, 1, -1, 0, '0, -1);
        do_div(1'b0, 32'd5, 32'd0, -1, -1, 0, '0, -1);

        // MTHI in IDLE, MTLO in the capture cycle.
        idle_cycle(1'b1, 0, 32'hDEAD_BEEF);
        idle_cycle(1'b1, -1, '0);
        do_div(1'b0, 32'd8, 32'd2, -1, 36, 1, 32'd1, -1);
        idle_cycle(1'b1, -1, '0);
        check("mtlo_lost_lo", {32'd0, lo}, 64'd4);

        // flush together with a request: nothing is accepted.
        @(posedge clk); #1;
        req_valid = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        check("fw.ready", {63'd0, req_ready}, 64'd0);
        check("fw.busy", {63'd0, busy}, 64'd0);
        idle_cycle(1'b1, -1, '0);
        idle_cycle(1'b1, -1, '0);

        // Randomized divides with flushes and MT writes.
        for (int n = 0; n < 24; n++) begin
            sgn = 1'($urandom_range(1));
            a   = $urandom;
            b   = ($urandom_range(3) == 0) ? 32'($urandom_range(15)) : $urandom;
            if (b == 32'd0) b = 32'd1;
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            fa = ($urandom_range(3) == 0) ? int'($urandom_range(35, 1)) : -1;
            ma = ($urandom_range(9) < 3) ? int'($urandom_range(36, 0)) : -1;
            do_div(sgn, a, b, fa, ma, int'($urandom_range(2)), $urandom, -1);
        end
        idle_cycle(1'b1, -1, '0);

        // Watchdog abort, error stays sticky afterwards.
        do_timeout(32'd77, 32'd3);
        idle_cycle(1'b0, -1, '0);
        idle_cycle(1'b1, -1, '0);
        do_div(1'b0, 32'd1000, 32'd10, -1, -1, 0, '0, -1);
        idle_cycle(1'b1, -1, '0);

        // Asynchronous reset in cycle 20 of a divide.
        do_div(1'b0, 32'd12345, 32'd11, -1, -1, 0, '0, 20);
        for (int i = 0; i < 20; i++) idle_cycle(1'b0, -1, '0);
        idle_cycle(1'b1, -1, '0);
        do_div(1'b1, 32'hFFFF_FF00, 32'd16, -1, -1, 0, '0, -1);
        idle_cycle(1'b1, -1, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
